// File: rtl/caches_types_pkg.sv
// Shared types and constants for the two-core cache/bus subsystem.
package caches_types_pkg;

  localparam int CPUS     = 2;
  // Words per dcache block; every fill, forward and writeback is this many beats.
  localparam int BLKWORDS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    IFETCH,
    WB0,
    WB1,
    SNOOP,
    UPG,
    FWD0,
    FWD1,
    FILL0,
    FILL1
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter. The pointer names the preferred core and flips
// every time the owner of this arbiter accepts a grant.
module rr_arbiter (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt,
  output logic       any
);

  logic ptr;

  // Preference pointer, flipped once per accepted grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  assign any = |req;
  assign gnt = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: serialises icache fetches, dcache fills,
// writebacks and upgrades onto one RAM port, snooping the other dcache and
// forwarding dirty blocks cache-to-cache while writing them back.
module coherence_bus_ctrl
  import caches_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  input  logic [CPUS-1:0]       cctrans,
  input  logic [CPUS-1:0]       ccwrite,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  bus_state_t state, state_n;
  logic       req, req_n;
  logic       oth;
  logic       inv_q;
  word_t      snaddr_q;

  logic [CPUS-1:0] dreq;
  logic            d_any, d_gnt, d_adv;
  logic            i_any, i_gnt, i_adv;
  logic            win;
  logic            access;
  logic            snoop_hold;

  // A plain dREN counts as a dcache request so a core that lost arbitration
  // on its cctrans pulse is still picked up on the next IDLE cycle.
  assign dreq   = dREN | dWEN | cctrans;
  assign access = (ramstate == ACCESS);
  assign oth    = ~req;
  assign win    = d_any ? d_gnt : i_gnt;
  assign d_adv  = (state == IDLE) && d_any;
  assign i_adv  = (state == IDLE) && !d_any && i_any;

  rr_arbiter u_darb (
    .CLK     (CLK),
    .nRST    (nRST),
    .req     (dreq),
    .advance (d_adv),
    .gnt     (d_gnt),
    .any     (d_any)
  );

  rr_arbiter u_iarb (
    .CLK     (CLK),
    .nRST    (nRST),
    .req     (iREN),
    .advance (i_adv),
    .gnt     (i_gnt),
    .any     (i_any)
  );

  // State, granted core, and the snoop address/invalidate captured in SNOOP
  // so they stay stable while the requester steps its beat address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      req      <= 1'b0;
      inv_q    <= 1'b0;
      snaddr_q <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      if (state == SNOOP) begin
        inv_q    <= ccwrite[req];
        snaddr_q <= daddr[req];
      end
    end
  end

  // Next-state selection; beats only advance on a RAM ACCESS cycle.
  always_comb begin
    state_n = state;
    req_n   = req;
    unique case (state)
      IDLE: begin
        if (d_any) begin
          req_n = win;
          if (dWEN[win] && !cctrans[win]) begin
            state_n = WB0;
          end else begin
            state_n = SNOOP;
          end
        end else if (i_any) begin
          req_n   = win;
          state_n = IFETCH;
        end
      end
      IFETCH: if (access) state_n = IDLE;
      WB0:    if (access) state_n = WB1;
      WB1:    if (access) state_n = IDLE;
      SNOOP: begin
        if (ccwrite[oth]) begin
          state_n = FWD0;
        end else if (ccwrite[req] && !dREN[req]) begin
          state_n = UPG;
        end else begin
          state_n = FILL0;
        end
      end
      UPG:    state_n = IDLE;
      FWD0:   if (access) state_n = FWD1;
      FWD1:   if (access) state_n = IDLE;
      FILL0:  if (access) state_n = FILL1;
      FILL1:  if (access) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign snoop_hold = (state == UPG)  || (state == FWD0)  || (state == FWD1) ||
                      (state == FILL0) || (state == FILL1);

  // Output decode; IDLE leaves every output at its reset value.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    if (state == SNOOP) begin
      ccwait[oth]      = 1'b1;
      ccinv[oth]       = ccwrite[req];
      ccsnoopaddr[oth] = daddr[req];
    end else if (snoop_hold) begin
      ccwait[oth]      = 1'b1;
      ccinv[oth]       = inv_q;
      ccsnoopaddr[oth] = snaddr_q;
    end

    unique case (state)
      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[req];
        iload[req] = ramload;
        if (access) iwait[req] = 1'b0;
      end
      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (access) dwait[req] = 1'b0;
      end
      UPG: begin
        dwait[req] = 1'b0;
      end
      FWD0, FWD1: begin
        ramWEN     = 1'b1;
        ramaddr    = daddr[oth];
        ramstore   = dstore[oth];
        dload[req] = dstore[oth];
        if (access) begin
          dwait[req] = 1'b0;
          dwait[oth] = 1'b0;
        end
      end
      FILL0, FILL1: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[req];
        dload[req] = ramload;
        if (access) dwait[req] = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: a latency-programmable RAM model,
// queues of expected RAM traffic and per-core load data, and a negedge monitor.
module tb_coherence_bus_ctrl;
  import caches_types_pkg::*;

  logic            CLK;
  logic            nRST;
  logic [1:0]      iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]      iwait;
  logic [1:0][31:0] iload;
  logic [1:0]      dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]      dwait;
  logic [1:0][31:0] dload;
  logic [1:0]      cctrans, ccwrite;
  logic [1:0]      ccwait, ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic            ramREN, ramWEN;
  logic [31:0]     ramaddr, ramstore, ramload;
  logic [1:0]      ramstate;

  coherence_bus_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic care; logic [31:0] d; } dl_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  dl_t         exp_dl0[$];
  dl_t         exp_dl1[$];
  logic [31:0] exp_il0[$];
  logic [31:0] exp_sa [2];
  logic        exp_inv[2];
  bit          snoop_ok[2];
  int          dptr_m = 0;
  int          lat = 0;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return a ^ 32'h5A5A0000;
  endfunction

  task automatic push_dl(input int c, input logic care, input logic [31:0] d);
    dl_t e;
    e.care = care;
    e.d    = d;
    if (c == 0) exp_dl0.push_back(e);
    else        exp_dl1.push_back(e);
  endtask

  // RAM model: BUSY for 'lat' cycles, then one ACCESS cycle per beat.
  initial begin
    int cnt;
    cnt = 0;
    ramstate = FREE;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (ramREN || ramWEN) begin
        if (cnt < lat) begin
          ramstate = BUSY;
          cnt++;
        end else begin
          ramstate = ACCESS;
          cnt = 0;
        end
      end else begin
        ramstate = FREE;
        cnt = 0;
      end
      ramload = ramREN ? rdat(ramaddr) : 32'h0;
    end
  end

  // Monitor: pops scoreboard entries as the DUT completes beats.
  initial begin
    wr_t w;
    dl_t e;
    logic [31:0] a;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        if (ramstate == ACCESS && ramWEN) begin
          if (exp_wr.size() == 0) check_eq("ram_wr_extra", {31'b0, ramWEN}, 32'h0);
          else begin
            w = exp_wr.pop_front();
            check_eq("ram_wr_addr", ramaddr, w.a);
            check_eq("ram_wr_data", ramstore, w.d);
          end
        end
        if (ramstate == ACCESS && ramREN) begin
          if (exp_rd.size() == 0) check_eq("ram_rd_extra", {31'b0, ramREN}, 32'h0);
          else begin
            a = exp_rd.pop_front();
            check_eq("ram_rd_addr", ramaddr, a);
          end
        end
        if (!dwait[0]) begin
          if (exp_dl0.size() == 0) check_eq("dwait0_extra", {31'b0, dwait[0]}, 32'h1);
          else begin
            e = exp_dl0.pop_front();
            if (e.care) check_eq("dload0", dload[0], e.d);
          end
        end
        if (!dwait[1]) begin
          if (exp_dl1.size() == 0) check_eq("dwait1_extra", {31'b0, dwait[1]}, 32'h1);
          else begin
            e = exp_dl1.pop_front();
            if (e.care) check_eq("dload1", dload[1], e.d);
          end
        end
        if (!iwait[0]) begin
          if (exp_il0.size() == 0) check_eq("iwait0_extra", {31'b0, iwait[0]}, 32'h1);
          else check_eq("iload0", iload[0], exp_il0.pop_front());
        end
        if (!iwait[1]) check_eq("iwait1_extra", {31'b0, iwait[1]}, 32'h1);
        for (int c = 0; c < 2; c++) begin
          if (ccwait[c]) begin
            if (!snoop_ok[c]) check_eq("ccwait_unexp", {31'b0, ccwait[c]}, 32'h0);
            else begin
              check_eq("ccsnoopaddr", ccsnoopaddr[c], exp_sa[c]);
              check_eq("ccinv", {31'b0, ccinv[c]}, {31'b0, exp_inv[c]});
            end
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_iwait"}, {30'b0, iwait}, 32'h3);
    check_eq({tag, "_dwait"}, {30'b0, dwait}, 32'h3);
    check_eq({tag, "_cc"}, {28'b0, ccwait, ccinv}, 32'h0);
    check_eq({tag, "_snaddr"}, ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
    check_eq({tag, "_ramctl"}, {30'b0, ramREN, ramWEN}, 32'h0);
    check_eq({tag, "_ramaddr"}, ramaddr | ramstore, 32'h0);
    check_eq({tag, "_loads"}, iload[0] | iload[1] | dload[0] | dload[1], 32'h0);
  endtask

  task automatic clear_inputs();
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0;
    snoop_ok[0] = 0; snoop_ok[1] = 0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    dptr_m = 0;
  endtask

  // Waits for dwait[c] low; returns the full dwait vector seen that cycle.
  task automatic wait_dw(input int c, output logic [1:0] seen);
    bit ok;
    ok = 0;
    seen = 2'b11;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (dwait[c] == 1'b0) begin
        ok = 1;
        seen = dwait;
        break;
      end
    end
    if (!ok) check_eq("timeout_dwait", {31'b0, dwait[c]}, 32'h0);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_any(output int c);
    bit ok;
    ok = 0;
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (dwait != 2'b11) begin
        ok = 1;
        c = dwait[0] ? 1 : 0;
        break;
      end
    end
    if (!ok) check_eq("timeout_any", {30'b0, dwait}, 32'h0);
    @(posedge CLK);
    #1;
  endtask

  // kind: 0 read miss, 1 write miss, 2 upgrade, 3 eviction.
  task automatic dtxn(input int c, input int kind, input logic [31:0] addr,
                      input logic dirty, input logic [31:0] d0, input logic [31:0] d1);
    int o;
    logic [1:0] seen;
    o = 1 - c;
    if (kind == 3) begin
      exp_wr.push_back({addr, d0});
      exp_wr.push_back({addr + 32'd4, d1});
      push_dl(c, 1'b0, 32'h0);
      push_dl(c, 1'b0, 32'h0);
      dWEN[c] = 1'b1; daddr[c] = addr; dstore[c] = d0;
      wait_dw(c, seen);
      daddr[c] = addr + 32'd4; dstore[c] = d1;
      wait_dw(c, seen);
      dWEN[c] = 1'b0;
    end else begin
      snoop_ok[o] = 1;
      exp_sa[o]   = addr;
      exp_inv[o]  = (kind != 0);
      ccwrite[o]  = dirty;
      if (dirty) begin
        daddr[o] = addr; dstore[o] = d0;
        exp_wr.push_back({addr, d0});
        exp_wr.push_back({addr + 32'd4, d1});
        push_dl(c, 1'b1, d0); push_dl(c, 1'b1, d1);
        push_dl(o, 1'b0, 32'h0); push_dl(o, 1'b0, 32'h0);
      end else if (kind == 2) begin
        push_dl(c, 1'b0, 32'h0);
      end else begin
        exp_rd.push_back(addr);
        exp_rd.push_back(addr + 32'd4);
        push_dl(c, 1'b1, rdat(addr)); push_dl(c, 1'b1, rdat(addr + 32'd4));
      end
      dREN[c] = (kind != 2); ccwrite[c] = (kind != 0); cctrans[c] = 1'b1; daddr[c] = addr;
      @(posedge CLK);
      #1;
      cctrans[c] = 1'b0;
      wait_dw(c, seen);
      if (dirty) check_eq("fwd_dwait_pair0", {30'b0, seen}, 32'h0);
      if (kind != 2 || dirty) begin
        daddr[c] = addr + 32'd4;
        if (dirty) begin daddr[o] = addr + 32'd4; dstore[o] = d1; end
        wait_dw(c, seen);
        if (dirty) check_eq("fwd_dwait_pair1", {30'b0, seen}, 32'h0);
      end
      dREN[c] = 1'b0; ccwrite = '0;
      snoop_ok[o] = 0;
    end
    dptr_m ^= 1;
  endtask

  // Both cores raise a clean read miss in the same cycle.
  task automatic dual(input logic [31:0] a0, input logic [31:0] a1);
    int win, lose, first;
    logic [1:0] seen;
    logic [31:0] wa, la;
    win  = dptr_m;
    lose = 1 - win;
    wa = win ? a1 : a0;
    la = win ? a0 : a1;
    snoop_ok[0] = 1; snoop_ok[1] = 1;
    exp_sa[1] = a0; exp_sa[0] = a1;
    exp_inv[0] = 1'b0; exp_inv[1] = 1'b0;
    exp_rd.push_back(wa); exp_rd.push_back(wa + 32'd4);
    exp_rd.push_back(la); exp_rd.push_back(la + 32'd4);
    push_dl(win, 1'b1, rdat(wa));  push_dl(win, 1'b1, rdat(wa + 32'd4));
    push_dl(lose, 1'b1, rdat(la)); push_dl(lose, 1'b1, rdat(la + 32'd4));
    dREN = 2'b11; cctrans = 2'b11; daddr[0] = a0; daddr[1] = a1;
    @(posedge CLK);
    #1;
    cctrans = 2'b00;
    wait_any(first);
    check_eq("arb_first", first, win);
    daddr[win] = wa + 32'd4;
    wait_dw(win, seen);
    dREN[win] = 1'b0;
    wait_dw(lose, seen);
    daddr[lose] = la + 32'd4;
    wait_dw(lose, seen);
    dREN[lose] = 1'b0;
    snoop_ok[0] = 0; snoop_ok[1] = 0;
    dptr_m ^= 1;
    dptr_m ^= 1;
  endtask

  initial begin
    int n;
    logic [1:0] seen;
    nRST = 1'b0;
    clear_inputs();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst0");
    nRST = 1'b1;

    // Instruction fetch with two BUSY cycles before ACCESS.
    lat = 2;
    exp_rd.push_back(32'h40);
    exp_il0.push_back(32'hDEADBEEF);
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (!iwait[0]) break;
    end
    check_eq("ifetch_latency", n, 3);
    @(posedge CLK);
    #1;
    iREN[0] = 1'b0;
    lat = 0;

    dtxn(1, 3, 32'h80,  1'b0, 32'h1, 32'h2);   // core1 eviction
    dtxn(0, 0, 32'h100, 1'b0, 32'h0, 32'h0);   // core0 read miss, core1 clean
    lat = 1;
    dtxn(0, 1, 32'h200, 1'b1, 32'hA, 32'hB);   // core0 write miss, core1 dirty
    lat = 0;
    dtxn(1, 2, 32'h300, 1'b0, 32'h0, 32'h0);   // core1 upgrade

    do_reset();
    dual(32'h400, 32'h500);
    // One more dcache transaction leaves the pointer on core1 for the repeat.
    dtxn(0, 3, 32'h700, 1'b0, 32'h11, 32'h22);
    dual(32'h800, 32'h900);

    // Reset in the middle of FILL1: second beat must never complete.
    lat = 4;
    snoop_ok[1] = 1; exp_sa[1] = 32'h600; exp_inv[1] = 1'b0;
    exp_rd.push_back(32'h600);
    push_dl(0, 1'b1, rdat(32'h600));
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h600;
    @(posedge CLK);
    #1;
    cctrans[0] = 1'b0;
    wait_dw(0, seen);
    daddr[0] = 32'h604;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    check_reset_outputs("rst_fill1");
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    lat = 0;
    repeat (4) @(posedge CLK);
    #1;

    check_eq("wr_left",  exp_wr.size(),  0);
    check_eq("rd_left",  exp_rd.size(),  0);
    check_eq("dl0_left", exp_dl0.size(), 0);
    check_eq("dl1_left", exp_dl1.size(), 0);
    check_eq("il0_left", exp_il0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
